// File: rtl/ram_arbiter_if.sv
// Bundled client A / client B / RAM toggle-handshake signals of ram_arbiter.
// The arbiter uses the slave modport; the surrounding system uses master.
interface ram_arbiter_if #(
   parameter int ADDR_BITS = 17
);
   logic [ADDR_BITS-1:0] a_addr;
   logic [7:0]           a_d;
   logic                 a_we;
   logic                 a_req;
   logic                 a_ack;
   logic [7:0]           a_q;
   logic [ADDR_BITS-1:0] b_addr;
   logic [7:0]           b_d;
   logic                 b_we;
   logic                 b_req;
   logic                 b_ack;
   logic [7:0]           b_q;
   logic [ADDR_BITS-1:0] ram_a;
   logic [7:0]           ram_d;
   logic                 ram_we;
   logic                 ram_req;
   logic                 ram_ack;
   logic [7:0]           ram_q;
   logic                 busy;
   logic                 last_grant;
   logic [1:0]           state_dbg;

   // Handshake rule for every channel: a request is pending while req != ack;
   // the requester flips req only when req == ack, and the responder flips ack
   // once the result (q) is valid. Addr/d/we stay stable while pending.
   modport slave (
      input  a_addr, a_d, a_we, a_req, b_addr, b_d, b_we, b_req, ram_ack, ram_q,
      output a_ack, a_q, b_ack, b_q, ram_a, ram_d, ram_we, ram_req, busy,
             last_grant, state_dbg
   );

   modport master (
      output a_addr, a_d, a_we, a_req, b_addr, b_d, b_we, b_req, ram_ack, ram_q,
      input  a_ack, a_q, b_ack, b_q, ram_a, ram_d, ram_we, ram_req, busy,
             last_grant, state_dbg
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake RAM port between two clients.
// Optional watchdog on the RAM wait enabled with `define RAM_ARB_TIMEOUT_EN.
module ram_arbiter #(
   parameter int ADDR_BITS      = 17,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         reset_n,
`ifdef RAM_ARB_TIMEOUT_EN
   output logic         timeout_err,
`endif
   ram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state, state_next;
   logic                 gnt, gnt_next;
   logic                 last_next;
   logic [ADDR_BITS-1:0] ram_a_next;
   logic [7:0]           ram_d_next;
   logic                 ram_we_next;
   logic                 ram_req_next;
   logic                 a_ack_next, b_ack_next;
   logic [7:0]           a_q_next, b_q_next;
   logic                 pend_a, pend_b, pick_b;
   logic                 complete, forced;

`ifdef RAM_ARB_TIMEOUT_EN
   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd, wd_next;
   logic        timeout_next;
`endif

   assign pend_a = bus.a_req ^ bus.a_ack;
   assign pend_b = bus.b_req ^ bus.b_ack;
   // On a tie, the client that was not served last wins.
   assign pick_b = pend_b & (~pend_a | ~bus.last_grant);

   assign bus.busy      = (state != S_IDLE);
   assign bus.state_dbg = state;

   always_comb begin
      state_next   = state;
      gnt_next     = gnt;
      last_next    = bus.last_grant;
      ram_a_next   = bus.ram_a;
      ram_d_next   = bus.ram_d;
      ram_we_next  = bus.ram_we;
      ram_req_next = bus.ram_req;
      a_ack_next   = bus.a_ack;
      b_ack_next   = bus.b_ack;
      a_q_next     = bus.a_q;
      b_q_next     = bus.b_q;
      complete     = 1'b0;
      forced       = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      wd_next      = wd;
      timeout_next = timeout_err;
`endif
      case (state)
         S_IDLE: begin
            if (pend_a || pend_b) begin
               gnt_next     = pick_b;
               last_next    = pick_b;
               ram_a_next   = pick_b ? bus.b_addr : bus.a_addr;
               ram_d_next   = pick_b ? bus.b_d    : bus.a_d;
               ram_we_next  = pick_b ? bus.b_we   : bus.a_we;
               ram_req_next = ~bus.ram_req;
               state_next   = S_WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
               wd_next      = 16'd0;
`endif
            end
         end
         S_ISSUE: state_next = S_WAIT;
         S_WAIT: begin
            if (bus.ram_req == bus.ram_ack) begin
               complete = 1'b1;
            end
`ifdef RAM_ARB_TIMEOUT_EN
            else if (wd == WD_LIMIT) begin
               // Give up on the RAM: realign its toggle and report 8'hFF.
               complete     = 1'b1;
               forced       = 1'b1;
               ram_req_next = bus.ram_ack;
               timeout_next = 1'b1;
            end else begin
               wd_next = wd + 16'd1;
            end
`endif
            if (complete) begin
               state_next = S_DONE;
               if (gnt) begin
                  b_ack_next = ~bus.b_ack;
                  if (forced)           b_q_next = 8'hFF;
                  else if (!bus.ram_we) b_q_next = bus.ram_q;
               end else begin
                  a_ack_next = ~bus.a_ack;
                  if (forced)           a_q_next = 8'hFF;
                  else if (!bus.ram_we) a_q_next = bus.ram_q;
               end
            end
         end
         // Dead cycle so a fresh client toggle is never judged against a stale ack.
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         gnt            <= 1'b0;
         bus.last_grant <= 1'b1;
         bus.ram_a      <= '0;
         bus.ram_d      <= 8'hFF;
         bus.ram_we     <= 1'b0;
         bus.ram_req    <= bus.ram_ack;
         bus.a_ack      <= bus.a_req;
         bus.b_ack      <= bus.b_req;
         bus.a_q        <= 8'hFF;
         bus.b_q        <= 8'hFF;
`ifdef RAM_ARB_TIMEOUT_EN
         wd             <= 16'd0;
         timeout_err    <= 1'b0;
`endif
      end else begin
         state          <= state_next;
         gnt            <= gnt_next;
         bus.last_grant <= last_next;
         bus.ram_a      <= ram_a_next;
         bus.ram_d      <= ram_d_next;
         bus.ram_we     <= ram_we_next;
         bus.ram_req    <= ram_req_next;
         bus.a_ack      <= a_ack_next;
         bus.b_ack      <= b_ack_next;
         bus.a_q        <= a_q_next;
         bus.b_q        <= b_q_next;
`ifdef RAM_ARB_TIMEOUT_EN
         wd             <= wd_next;
         timeout_err    <= timeout_next;
`endif
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: toggle-handshake RAM model plus a transaction-level
// reference (memory array, grant rule, expected RAM transaction queue).
module tb_ram_arbiter;
   localparam int ADDR_BITS = 17;
`ifdef RAM_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 255;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_BITS(ADDR_BITS)) bus ();
`ifdef RAM_ARB_TIMEOUT_EN
   logic timeout_err;
`endif

   ram_arbiter #(.ADDR_BITS(ADDR_BITS), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
`ifdef RAM_ARB_TIMEOUT_EN
      .timeout_err (timeout_err),
`endif
      .bus         (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] init_val(input logic [16:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   // RAM model: acks ram_delay negedges after it sees a pending request.
   logic        ram_hold  = 1'b0;
   int          ram_delay = 4;
   int          ram_cnt   = 0;
   logic [7:0]  ram_mem [int];
   logic [25:0] log_q [$];

   always @(negedge clk) begin
      if (!reset_n || bus.ram_req === bus.ram_ack) begin
         ram_cnt = 0;
      end else if (!ram_hold) begin
         ram_cnt++;
         if (ram_cnt >= ram_delay) begin
            if (bus.ram_we) ram_mem[int'(bus.ram_a)] = bus.ram_d;
            else bus.ram_q = ram_mem.exists(int'(bus.ram_a)) ? ram_mem[int'(bus.ram_a)]
                                                             : init_val(bus.ram_a);
            log_q.push_back({bus.ram_we, bus.ram_a, bus.ram_d});
            bus.ram_ack = ~bus.ram_ack;
            ram_cnt = 0;
         end
      end
   end

   // Reference model: expected transactions, client data and last grant.
   logic [7:0]  ref_mem [int];
   logic [25:0] exp_q [$];
   logic        exp_last;
   logic [7:0]  exp_aq, exp_bq;

   task automatic ref_reset();
      exp_last = 1'b1;
      exp_aq   = 8'hFF;
      exp_bq   = 8'hFF;
   endtask

   task automatic ref_serve(input logic client, input logic we, input logic [16:0] addr,
                            input logic [7:0] d);
      logic [7:0] v;
      exp_q.push_back({we, addr, d});
      if (we) ref_mem[int'(addr)] = d;
      else begin
         v = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : init_val(addr);
         if (client) exp_bq = v;
         else        exp_aq = v;
      end
      exp_last = client;
   endtask

   task automatic drive_a(input logic we, input logic [16:0] addr, input logic [7:0] d);
      bus.a_we = we; bus.a_addr = addr; bus.a_d = d; bus.a_req = ~bus.a_req;
   endtask

   task automatic drive_b(input logic we, input logic [16:0] addr, input logic [7:0] d);
      bus.b_we = we; bus.b_addr = addr; bus.b_d = d; bus.b_req = ~bus.b_req;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ref_reset();
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!(bus.a_ack === bus.a_req && bus.b_ack === bus.b_req && bus.busy === 1'b0)
             && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 32'(n < 200), 32'd1);
   endtask

   task automatic check_log(input string tag);
      check({tag, "_nlog"}, log_q.size(), exp_q.size());
      while (exp_q.size() > 0 && log_q.size() > 0)
         check({tag, "_log"}, 32'(log_q.pop_front()), 32'(exp_q.pop_front()));
      exp_q.delete();
      log_q.delete();
   endtask

   task automatic run_round(input string tag, input logic do_a, input logic do_b,
                            input logic wa, input logic wb,
                            input logic [16:0] aa, input logic [16:0] ab,
                            input logic [7:0] da, input logic [7:0] db);
      logic b_first;
      if (do_a) drive_a(wa, aa, da);
      if (do_b) drive_b(wb, ab, db);
      b_first = (do_a && do_b) ? ~exp_last : do_b;
      if (!b_first) begin
         if (do_a) ref_serve(1'b0, wa, aa, da);
         if (do_b) ref_serve(1'b1, wb, ab, db);
      end else begin
         ref_serve(1'b1, wb, ab, db);
         if (do_a) ref_serve(1'b0, wa, aa, da);
      end
      wait_idle(tag);
      check({tag, "_aq"},   bus.a_q, exp_aq);
      check({tag, "_bq"},   bus.b_q, exp_bq);
      check({tag, "_last"}, bus.last_grant, exp_last);
      check({tag, "_rsync"}, bus.ram_req, bus.ram_ack);
      check_log(tag);
   endtask

   task automatic wait_ack_a(input string tag);
      int n = 0;
      while (bus.a_ack !== bus.a_req && n < 100) begin @(negedge clk); n++; end
      check({tag, "_aack"}, 32'(n < 100), 32'd1);
   endtask

   task automatic wait_ack_b(input string tag);
      int n = 0;
      while (bus.b_ack !== bus.b_req && n < 100) begin @(negedge clk); n++; end
      check({tag, "_back"}, 32'(n < 100), 32'd1);
   endtask

   logic [16:0] ca [8], cb [8];
   logic        cwa [8], cwb [8];
   logic [7:0]  cda [8], cdb [8];

   initial begin
      int lat;
      logic b_first;
      logic [1:0] pat;
      bus.a_req = 1'b0; bus.b_req = 1'b0; bus.ram_ack = 1'b0; bus.ram_q = 8'h00;
      bus.a_addr = '0; bus.a_d = 8'h00; bus.a_we = 1'b0;
      bus.b_addr = '0; bus.b_d = 8'h00; bus.b_we = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      ref_reset();
      check("rst_busy", bus.busy, 1'b0);
      check("rst_last", bus.last_grant, 1'b1);
      check("rst_aq", bus.a_q, 8'hFF);
      check("rst_bq", bus.b_q, 8'hFF);
      check("rst_ram_a", bus.ram_a, 17'h0);
      check("rst_ram_d", bus.ram_d, 8'hFF);
      check("rst_ram_we", bus.ram_we, 1'b0);
      check("rst_rsync", bus.ram_req, 1'b0);
      check("rst_aack", bus.a_ack, 1'b0);
      check("rst_back", bus.b_ack, 1'b0);
`ifdef RAM_ARB_TIMEOUT_EN
      check("rst_toerr", timeout_err, 1'b0);
`endif
      reset_n = 1'b1;
      @(negedge clk);

      // Single read A with a 5-cycle req-to-ack turnaround.
      ram_mem[32'h123] = 8'h5A;
      ref_mem[32'h123] = 8'h5A;
      drive_a(1'b0, 17'h00123, 8'h11);
      ref_serve(1'b0, 1'b0, 17'h00123, 8'h11);
      lat = 0;
      while (bus.a_ack !== bus.a_req && lat < 50) begin @(negedge clk); lat++; end
      check("rda_lat", lat, 5);
      check("rda_aq", bus.a_q, 8'h5A);
      check("rda_ram_a", bus.ram_a, 17'h00123);
      check("rda_ram_we", bus.ram_we, 1'b0);
      check("rda_back", bus.b_ack, 1'b0);
      wait_idle("rda");
      check_log("rda");

      // Single write B leaves b_q untouched.
      run_round("wrb", 1'b0, 1'b1, 1'b0, 1'b1, 17'h0, 17'h1FFFF, 8'h00, 8'hC3);
      check("wrb_ram_a", bus.ram_a, 17'h1FFFF);
      check("wrb_ram_d", bus.ram_d, 8'hC3);
      check("wrb_ram_we", bus.ram_we, 1'b1);

      // Simultaneous toggles out of reset: A first, then B.
      do_reset();
      run_round("tie", 1'b1, 1'b1, 1'b0, 1'b0, 17'h00040, 17'h00041, 8'h01, 8'h02);

      // Both clients re-toggle immediately for 8 rounds each.
      for (int i = 0; i < 8; i++) begin
         ca[i] = 17'h100 + 17'(i); cb[i] = 17'h200 + 17'(i);
         cwa[i] = 1'($urandom_range(0, 1)); cwb[i] = 1'($urandom_range(0, 1));
         cda[i] = 8'($urandom); cdb[i] = 8'($urandom);
      end
      b_first = ~exp_last;
      for (int i = 0; i < 8; i++) begin
         if (!b_first) begin
            ref_serve(1'b0, cwa[i], ca[i], cda[i]); ref_serve(1'b1, cwb[i], cb[i], cdb[i]);
         end else begin
            ref_serve(1'b1, cwb[i], cb[i], cdb[i]); ref_serve(1'b0, cwa[i], ca[i], cda[i]);
         end
      end
      fork
         begin
            for (int i = 0; i < 8; i++) begin drive_a(cwa[i], ca[i], cda[i]); wait_ack_a("rr"); end
         end
         begin
            for (int j = 0; j < 8; j++) begin drive_b(cwb[j], cb[j], cdb[j]); wait_ack_b("rr"); end
         end
      join
      wait_idle("rr");
      check("rr_aq", bus.a_q, exp_aq);
      check("rr_bq", bus.b_q, exp_bq);
      check("rr_last", bus.last_grant, exp_last);
      check_log("rr");

      // Random rounds with colliding addresses and random RAM latency.
      for (int r = 0; r < 12; r++) begin
         ram_delay = $urandom_range(1, 5);
         pat = 2'($urandom_range(1, 3));
         run_round("rnd", pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   17'($urandom_range(0, 15)), 17'($urandom_range(0, 15)),
                   8'($urandom), 8'($urandom));
      end
      ram_delay = 4;

      // Reset while an A read is stuck in WAIT.
      ram_hold = 1'b1;
      drive_a(1'b0, 17'h00055, 8'h00);
      repeat (4) @(negedge clk);
      check("rstw_busy_pre", bus.busy, 1'b1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      ref_reset();
      check("rstw_rsync", bus.ram_req, bus.ram_ack);
      check("rstw_aack", bus.a_ack, bus.a_req);
      check("rstw_busy", bus.busy, 1'b0);
      check("rstw_last", bus.last_grant, 1'b1);
      check("rstw_aq", bus.a_q, 8'hFF);
      repeat (3) @(negedge clk);
      ram_hold = 1'b0;
      check("rstw_nlog", log_q.size(), 0);
      run_round("rstw_b", 1'b0, 1'b1, 1'b0, 1'b0, 17'h0, 17'h00077, 8'h00, 8'h00);

`ifdef RAM_ARB_TIMEOUT_EN
      // RAM never answers: watchdog forces completion after 16 WAIT cycles.
      check("to_pre", timeout_err, 1'b0);
      ram_hold = 1'b1;
      drive_a(1'b0, 17'h00099, 8'h00);
      lat = 0;
      while (bus.a_ack !== bus.a_req && lat < 60) begin @(negedge clk); lat++; end
      check("to_lat", lat, 17);
      check("to_aq", bus.a_q, 8'hFF);
      check("to_err", timeout_err, 1'b1);
      check("to_rsync", bus.ram_req, bus.ram_ack);
      exp_aq = 8'hFF;
      exp_last = 1'b0;
      ram_hold = 1'b0;
      wait_idle("to");
      run_round("to_b", 1'b0, 1'b1, 1'b0, 1'b0, 17'h0, 17'h00033, 8'h00, 8'h00);
      check("to_err_sticky", timeout_err, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
